cp0_unit: RTL

- Coprocessor-0 block for the 5-stage MIPS pipeline; responder to the pipeline controller's cp_oper command and the source of its jump_en (epc_ctrl) input.
- Holds Status, Cause, EPC and the handler base register.
- Executes MTC0 and ERET, serves MFC0 reads, and accepts one external interrupt line.
- Redirects the PC through a registered jump_en/jump_addr pulse.
- Sits beside the EXE stage; its operation enable comes from the controller's exe_en.

---
 rtl/cp0_unit_pkg.sv | 25 ++
 rtl/cp0_unit_irq_edge.sv | 26 ++
 rtl/cp0_unit.sv | 120 ++++++++++++
 3 files changed

// File: rtl/cp0_unit_pkg.sv
// Shared definitions for the coprocessor-0 block: cp_oper encodings,
// register indices, bit positions and the control state type.
package cp0_unit_pkg;

    localparam logic [1:0] CP_OPER_NONE  = 2'd0;
    localparam logic [1:0] CP_OPER_STORE = 2'd1;
    localparam logic [1:0] CP_OPER_ERET  = 2'd2;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_EHBR  = 5'd15;

    localparam int unsigned SR_IE    = 0;
    localparam int unsigned SR_EXL   = 1;
    localparam int unsigned CAUSE_IP = 10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HANDLER,
        ST_FLUSH_I,
        ST_FLUSH_R
    } cp0_state_t;

endpackage

// File: rtl/cp0_unit_irq_edge.sv
// Rising-edge detector on the external interrupt line with a sticky pending flag.
module cp0_unit_irq_edge (
    input  logic clk,
    input  logic rst,
    input  logic ir_in,
    input  logic clear,
    output logic ip
);

    logic ir_prev;

    // Runs regardless of stage enable; a fresh edge outranks a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ir_prev <= 1'b0;
            ip      <= 1'b0;
        end else begin
            ir_prev <= ir_in;
            if (ir_in && !ir_prev)
                ip <= 1'b1;
            else if (clear)
                ip <= 1'b0;
        end
    end

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor 0: Status/Cause/EPC/handler-base registers, MTC0/MFC0/ERET and
// a single external interrupt, redirecting the PC through a registered pulse.
module cp0_unit
    import cp0_unit_pkg::*;
#(
    parameter logic [31:0] EHBR_RESET = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        valid,
    input  logic        is_branch,
    input  logic [1:0]  oper,
    input  logic [4:0]  addr_r,
    output logic [31:0] data_r,
    input  logic [4:0]  addr_w,
    input  logic [31:0] data_w,
    input  logic [31:0] ret_addr,
    input  logic        ir_in,
    output logic        jump_en,
    output logic [31:0] jump_addr
);

    cp0_state_t  state, state_next;
    logic        sr_ie, sr_exl;
    logic [31:0] epc, ehbr;
    logic        ip;
    logic        accept, take, eret, store, flushing;

    cp0_unit_irq_edge u_irq (
        .clk   (clk),
        .rst   (rst),
        .ir_in (ir_in),
        .clear (take),
        .ip    (ip)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (en) begin
            case (state)
                ST_IDLE: begin
                    if (take)
                        state_next = ST_FLUSH_I;
                    else if (eret)
                        state_next = ST_FLUSH_R;
                end
                ST_HANDLER: begin
                    if (eret)
                        state_next = ST_FLUSH_R;
                end
                ST_FLUSH_I: state_next = ST_HANDLER;
                ST_FLUSH_R: state_next = ST_IDLE;
                default:    state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        accept   = en && valid;
        flushing = (state == ST_FLUSH_I) || (state == ST_FLUSH_R);
        take     = (state == ST_IDLE) && accept && ip && sr_ie && !sr_exl && !is_branch;
        eret     = !flushing && accept && !take && (oper == CP_OPER_ERET);
        store    = !flushing && accept && !take && (oper == CP_OPER_STORE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_ie     <= 1'b0;
            sr_exl    <= 1'b0;
            epc       <= '0;
            ehbr      <= EHBR_RESET;
            jump_en   <= 1'b0;
            jump_addr <= '0;
        end else if (take) begin
            epc       <= ret_addr;
            sr_exl    <= 1'b1;
            jump_addr <= ehbr;
            jump_en   <= 1'b1;
        end else if (eret) begin
            sr_exl    <= 1'b0;
            jump_addr <= epc;
            jump_en   <= 1'b1;
        end else if (store) begin
            case (addr_w)
                CP0_SR: begin
                    sr_ie  <= data_w[SR_IE];
                    sr_exl <= data_w[SR_EXL];
                end
                CP0_EPC:  epc  <= data_w;
                CP0_EHBR: ehbr <= data_w;
                default: ;
            endcase
        end else if (en && flushing) begin
            jump_en <= 1'b0;
        end
    end

    always_comb begin
        data_r = '0;
        case (addr_r)
            CP0_SR: begin
                data_r[SR_IE]  = sr_ie;
                data_r[SR_EXL] = sr_exl;
            end
            CP0_CAUSE: data_r[CAUSE_IP] = ip;
            CP0_EPC:   data_r = epc;
            CP0_EHBR:  data_r = ehbr;
            default:   data_r = '0;
        endcase
    end

endmodule
